// File: rtl/seg_scan_decoder.sv
// Reads a multiplexed 4-digit seven-segment bus back into hex digits.
// Each {an,seg} pattern must be held for STABLE_CYCLES edges before it is decoded once.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    input  logic        clear,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  bad_pattern,
    output logic        frame_done
);

    localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);

    // Returns {decodable, value}; anything outside the glyph table is undecodable.
    function automatic logic [4:0] decodeSeg(input logic [6:0] pattern);
        case (pattern)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    logic [10:0] sampleReg;
    logic [7:0]  cnt;
    logic        armed;

    logic [10:0] busNow;
    logic        busStable;
    logic [3:0]  selAn;
    logic        oneHot;
    logic        capture;
    logic [4:0]  decoded;
    logic [15:0] nextDigits;
    logic [3:0]  nextValid;
    logic [3:0]  nextBad;
    logic        frameHit;

    assign busNow    = {an, seg};
    assign busStable = (busNow == sampleReg);
    assign selAn     = sampleReg[10:7];
    assign oneHot    = (selAn != 4'd0) && ((selAn & (selAn - 4'd1)) == 4'd0);
    // The bus must still match on the capture edge itself, so a late glitch aborts the capture.
    assign capture   = busStable && (cnt == CntMax) && armed && oneHot;
    assign decoded   = decodeSeg(sampleReg[6:0]);

    always_comb begin
        nextDigits = digits;
        nextValid  = digit_valid;
        nextBad    = bad_pattern;
        for (int i = 0; i < 4; i++) begin
            if (selAn[i]) begin
                if (decoded[4]) begin
                    nextDigits[4*i +: 4] = decoded[3:0];
                    nextValid[i]         = 1'b1;
                end else begin
                    nextBad[i]   = 1'b1;
                    nextValid[i] = 1'b0;
                end
            end
        end
    end

    assign frameHit = (nextValid == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sampleReg   <= '0;
            cnt         <= '0;
            armed       <= 1'b1;
            digits      <= '0;
            digit_valid <= '0;
            bad_pattern <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!busStable) begin
                sampleReg <= busNow;
                cnt       <= '0;
                armed     <= 1'b1;
            end else if (cnt != CntMax) begin
                cnt <= cnt + 8'd1;
            end

            // clear overrides both the counter update above and any capture on this edge.
            if (clear) begin
                cnt         <= '0;
                armed       <= 1'b1;
                digits      <= '0;
                digit_valid <= '0;
                bad_pattern <= '0;
                frame_done  <= 1'b0;
            end else if (capture) begin
                armed       <= 1'b0;
                digits      <= nextDigits;
                bad_pattern <= nextBad;
                if (frameHit) begin
                    frame_done  <= 1'b1;
                    digit_valid <= '0;
                end else begin
                    digit_valid <= nextValid;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a run-length reference model predicts the
// outputs after every edge, and a separate monitor pops and compares them.
module tb_seg_scan_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        clear;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  bad_pattern;
    logic        frame_done;

    seg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .clear(clear),
        .digits(digits), .digit_valid(digit_valid),
        .bad_pattern(bad_pattern), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  vld;
        logic [3:0]  bad;
        logic        done;
    } expT;

    expT expQ[$];
    expT monE;
    int  nChecks = 0;
    int  nFails  = 0;

    logic [6:0] segTab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: a pattern is read when it has been seen on exactly STABLE+1
    // consecutive edges, counting from the edge it first appeared or the last clear.
    logic [10:0] prevBus;
    bit          havePrev;
    int          runLen;
    logic [3:0]  mDig[4];
    logic [3:0]  mVal;
    logic [3:0]  mBad;
    logic        mDone;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        havePrev = 0;
        runLen   = 0;
        for (int k = 0; k < 4; k++) mDig[k] = 4'h0;
        mVal  = 4'h0;
        mBad  = 4'h0;
        mDone = 1'b0;
    endtask

    task automatic modelEdge(input logic [3:0] a, input logic [6:0] s, input logic c);
        logic [10:0] bus;
        int          hit;
        int          idx;
        bus = {a, s};
        if (!havePrev || bus != prevBus || c) runLen = 1;
        else runLen++;
        prevBus  = bus;
        havePrev = 1;
        mDone    = 1'b0;
        if (c) begin
            for (int k = 0; k < 4; k++) mDig[k] = 4'h0;
            mVal = 4'h0;
            mBad = 4'h0;
        end else if (runLen == STABLE + 1 && $countones(a) == 1) begin
            idx = 0;
            for (int k = 0; k < 4; k++) if (a[k]) idx = k;
            hit = -1;
            for (int v = 0; v < 16; v++) if (segTab[v] == s) hit = v;
            if (hit >= 0) begin
                mDig[idx] = 4'(hit);
                mVal[idx] = 1'b1;
            end else begin
                mBad[idx] = 1'b1;
                mVal[idx] = 1'b0;
            end
            if (mVal == 4'hF) begin
                mDone = 1'b1;
                mVal  = 4'h0;
            end
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s, input logic c);
        expT e;
        @(negedge clk);
        an    = a;
        seg   = s;
        clear = c;
        modelEdge(a, s, c);
        e.dig  = {mDig[3], mDig[2], mDig[1], mDig[0]};
        e.vld  = mVal;
        e.bad  = mBad;
        e.done = mDone;
        expQ.push_back(e);
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int k = 0; k < n; k++) step(a, s, 1'b0);
    endtask

    task automatic checkZero(input string tag);
        chk({tag, "_digits"}, digits, 16'h0);
        chk({tag, "_valid"}, {12'h0, digit_valid}, 16'h0);
        chk({tag, "_bad"}, {12'h0, bad_pattern}, 16'h0);
        chk({tag, "_done"}, {15'h0, frame_done}, 16'h0);
    endtask

    // Asynchronous reset mid-cycle; outputs must drop before any clock edge.
    task automatic doReset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkZero("async_reset");
        modelReset();
        an    = 4'h0;
        seg   = 7'h00;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one prediction per clock edge, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            chk("digits", digits, monE.dig);
            chk("digit_valid", {12'h0, digit_valid}, {12'h0, monE.vld});
            chk("bad_pattern", {12'h0, bad_pattern}, {12'h0, monE.bad});
            chk("frame_done", {15'h0, frame_done}, {15'h0, monE.done});
        end
    end

    initial begin
        logic [3:0] ra;
        logic [6:0] rs;
        int         r;
        int         waitCyc;

        rst_n = 1'b0;
        an    = 4'h0;
        seg   = 7'h00;
        clear = 1'b0;
        modelReset();
        #12;
        checkZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic capture of 8 on digit 0, then hold with no further change.
        hold(4'b0001, 7'h7F, 5);
        hold(4'b0001, 7'h7F, 4);

        // Glitch before the capture edge, then a clean 2 on digit 1.
        hold(4'b0010, 7'h06, 3);
        hold(4'b0010, 7'h5B, 5);

        // Full frame 4321.
        step(4'b0000, 7'h00, 1'b1);
        hold(4'b0001, 7'h06, 6);
        hold(4'b0010, 7'h5B, 6);
        hold(4'b0100, 7'h4F, 6);
        hold(4'b1000, 7'h66, 6);
        hold(4'b0000, 7'h00, 3);

        // Undecodable blank on digit 2, then a valid E.
        hold(4'b0100, 7'h00, 6);
        hold(4'b0100, 7'h79, 6);

        // Multi-hot and empty selects are ignored.
        hold(4'b0011, 7'h3F, 10);
        hold(4'b0000, 7'h3F, 10);

        // clear on the capture edge wins, then the held pattern recaptures.
        hold(4'b1000, 7'h7F, 4);
        step(4'b1000, 7'h7F, 1'b1);
        hold(4'b1000, 7'h7F, 6);

        // Reset mid-count loses progress.
        hold(4'b0001, 7'h6F, 2);
        doReset();
        hold(4'b0001, 7'h6F, 6);

        // Randomized scan traffic.
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(9);
            if (r < 8) ra = 4'b0001 << $urandom_range(3);
            else if (r == 8) ra = 4'h0;
            else ra = 4'($urandom);
            if ($urandom_range(9) < 8) rs = segTab[$urandom_range(15)];
            else rs = 7'($urandom);
            if ($urandom_range(40) == 0) step(ra, rs, 1'b1);
            else if ($urandom_range(60) == 0) doReset();
            else hold(ra, rs, $urandom_range(1, 7));
        end

        waitCyc = 0;
        while (expQ.size() > 0 && waitCyc < 20) begin
            @(posedge clk);
            waitCyc++;
        end
        @(posedge clk);
        #2;
        chk("queue_drain", 16'(expQ.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
